// File: rtl/keyboard_register.sv
`default_nettype none
// ============================================================================
//  keyboard_register
//  PS/2 Set-2 scan-code stream to Hack keyboard-register value.
//  Revision: 1.0
// ============================================================================
module keyboard_register #(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        scan_ready,
    input  logic [7:0]  scan_code,
    output logic [15:0] keyboard,
    output logic        key_event
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_EXT       = 2'd1,
        ST_BREAK     = 2'd2,
        ST_EXT_BREAK = 2'd3
    } state_t;

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT_CYCLES - 1);

    logic             s1_q, s2_q, s3_q;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       kb_q, kb_d;
    logic [8:0]       held_q, held_d;
    logic             held_vld_q, held_vld_d;
    logic             key_event_q, key_event_d;

    logic             stb;
    logic             do_make, do_release, ext;
    logic [8:0]       key;
    logic [8:0]       map;

    // Returns {mapped, hack_code} for an {extended, scan_byte} key.
    function automatic logic [8:0] map_code(input logic [8:0] k);
        logic [8:0] r;
        r = 9'h000;
        case (k)
            9'h01C: r = {1'b1, 8'd65};  9'h032: r = {1'b1, 8'd66};
            9'h021: r = {1'b1, 8'd67};  9'h023: r = {1'b1, 8'd68};
            9'h024: r = {1'b1, 8'd69};  9'h02B: r = {1'b1, 8'd70};
            9'h034: r = {1'b1, 8'd71};  9'h033: r = {1'b1, 8'd72};
            9'h043: r = {1'b1, 8'd73};  9'h03B: r = {1'b1, 8'd74};
            9'h042: r = {1'b1, 8'd75};  9'h04B: r = {1'b1, 8'd76};
            9'h03A: r = {1'b1, 8'd77};  9'h031: r = {1'b1, 8'd78};
            9'h044: r = {1'b1, 8'd79};  9'h04D: r = {1'b1, 8'd80};
            9'h015: r = {1'b1, 8'd81};  9'h02D: r = {1'b1, 8'd82};
            9'h01B: r = {1'b1, 8'd83};  9'h02C: r = {1'b1, 8'd84};
            9'h03C: r = {1'b1, 8'd85};  9'h02A: r = {1'b1, 8'd86};
            9'h01D: r = {1'b1, 8'd87};  9'h022: r = {1'b1, 8'd88};
            9'h035: r = {1'b1, 8'd89};  9'h01A: r = {1'b1, 8'd90};
            9'h045: r = {1'b1, 8'd48};  9'h016: r = {1'b1, 8'd49};
            9'h01E: r = {1'b1, 8'd50};  9'h026: r = {1'b1, 8'd51};
            9'h025: r = {1'b1, 8'd52};  9'h02E: r = {1'b1, 8'd53};
            9'h036: r = {1'b1, 8'd54};  9'h03D: r = {1'b1, 8'd55};
            9'h03E: r = {1'b1, 8'd56};  9'h046: r = {1'b1, 8'd57};
            9'h029: r = {1'b1, 8'd32};  9'h05A: r = {1'b1, 8'd128};
            9'h066: r = {1'b1, 8'd129}; 9'h076: r = {1'b1, 8'd140};
            9'h005: r = {1'b1, 8'd141}; 9'h006: r = {1'b1, 8'd142};
            9'h004: r = {1'b1, 8'd143}; 9'h00C: r = {1'b1, 8'd144};
            9'h003: r = {1'b1, 8'd145}; 9'h00B: r = {1'b1, 8'd146};
            9'h083: r = {1'b1, 8'd147}; 9'h00A: r = {1'b1, 8'd148};
            9'h001: r = {1'b1, 8'd149}; 9'h009: r = {1'b1, 8'd150};
            9'h078: r = {1'b1, 8'd151}; 9'h007: r = {1'b1, 8'd152};
            9'h16B: r = {1'b1, 8'd130}; 9'h175: r = {1'b1, 8'd131};
            9'h174: r = {1'b1, 8'd132}; 9'h172: r = {1'b1, 8'd133};
            9'h16C: r = {1'b1, 8'd134}; 9'h169: r = {1'b1, 8'd135};
            9'h17D: r = {1'b1, 8'd136}; 9'h17A: r = {1'b1, 8'd137};
            9'h170: r = {1'b1, 8'd138}; 9'h171: r = {1'b1, 8'd139};
            default: r = 9'h000;
        endcase
        return r;
    endfunction

    assign stb = s2_q & ~s3_q;
    assign key = {ext, scan_code};
    assign map = map_code(key);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        kb_d        = kb_q;
        held_d      = held_q;
        held_vld_d  = held_vld_q;
        do_make     = 1'b0;
        do_release  = 1'b0;
        ext         = 1'b0;

        if (stb) begin
            // A byte arriving on the expiry cycle is still taken in the current state.
            cnt_d = '0;
            case (state_q)
                ST_IDLE: begin
                    if (scan_code == 8'hE0)      state_d = ST_EXT;
                    else if (scan_code == 8'hF0) state_d = ST_BREAK;
                    else if (scan_code != 8'hAA && scan_code != 8'hFA && scan_code != 8'hFE)
                        do_make = 1'b1;
                end
                ST_EXT: begin
                    if (scan_code == 8'hF0)      state_d = ST_EXT_BREAK;
                    else if (scan_code != 8'hE0) begin
                        do_make = 1'b1;
                        ext     = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_BREAK: begin
                    if (scan_code == 8'hE0)      state_d = ST_EXT_BREAK;
                    else if (scan_code != 8'hF0) begin
                        do_release = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end
                default: begin
                    if (scan_code != 8'hF0 && scan_code != 8'hE0) begin
                        do_release = 1'b1;
                        ext        = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end
            endcase
        end else if (state_q != ST_IDLE) begin
            if (cnt_q == c_cnt_last) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = '0;
        end

        if (do_make && map[8]) begin
            kb_d       = map[7:0];
            held_d     = key;
            held_vld_d = 1'b1;
        end
        // Only the most recently made key may clear the register.
        if (do_release && held_vld_q && (held_q == key)) begin
            kb_d       = 8'h00;
            held_d     = 9'h000;
            held_vld_d = 1'b0;
        end

        key_event_d = (kb_d != kb_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            s3_q        <= 1'b0;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            kb_q        <= 8'h00;
            held_q      <= 9'h000;
            held_vld_q  <= 1'b0;
            key_event_q <= 1'b0;
        end else begin
            s1_q        <= scan_ready;
            s2_q        <= s1_q;
            s3_q        <= s2_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            kb_q        <= kb_d;
            held_q      <= held_d;
            held_vld_q  <= held_vld_d;
            key_event_q <= key_event_d;
        end
    end

    assign keyboard  = {8'h00, kb_q};
    assign key_event = key_event_q;

endmodule
`default_nettype wire

// File: tb/tb_keyboard_register.sv
`default_nettype none
// ============================================================================
//  tb_keyboard_register
//  Directed self-checking bench for keyboard_register.
//  Revision: 1.0
// ============================================================================
module tb_keyboard_register;

    logic        clk;
    logic        reset_n;
    logic        scan_ready;
    logic [7:0]  scan_code;
    logic [15:0] keyboard;
    logic        key_event;

    int tests;
    int fails;
    int ev_cnt;
    int ev_base;

    keyboard_register #(.TIMEOUT_CYCLES(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .scan_ready (scan_ready),
        .scan_code  (scan_code),
        .keyboard   (keyboard),
        .key_event  (key_event)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)              ev_cnt <= 0;
        else if (key_event === 1'b1) ev_cnt <= ev_cnt + 1;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        scan_code  = b;
        scan_ready = 1'b1;
        repeat (4) @(negedge clk);
        scan_ready = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        reset_n    = 1'b0;
        scan_ready = 1'b0;
        scan_code  = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_keyboard", keyboard, 16'd0);
        check("reset_event", {15'd0, key_event}, 16'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Make 1C with cycle-exact latency checks.
        ev_base    = ev_cnt;
        scan_code  = 8'h1C;
        scan_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("lat_k", keyboard, 16'd0);
        @(negedge clk);
        check("lat_k1", keyboard, 16'd0);
        @(negedge clk);
        check("lat_k2_kb", keyboard, 16'd65);
        check("lat_k2_ev", {15'd0, key_event}, 16'd1);
        @(negedge clk);
        check("lat_k3_ev", {15'd0, key_event}, 16'd0);
        scan_ready = 1'b0;
        repeat (4) @(negedge clk);
        send_byte(8'hF0);
        check("break_pending", keyboard, 16'd65);
        send_byte(8'h1C);
        check("break_1C", keyboard, 16'd0);
        check("events_A", ev_cnt - ev_base, 16'd2);

        // Extended up arrow, then keypad 8 (unmapped).
        ev_base = ev_cnt;
        send_byte(8'hE0);
        send_byte(8'h75);
        check("ext_up", keyboard, 16'd131);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        check("ext_up_rel", keyboard, 16'd0);
        send_byte(8'h75);
        check("kp8_unmapped", keyboard, 16'd0);
        check("events_up", ev_cnt - ev_base, 16'd2);

        // Overlapping keys: older release does not clear newer key.
        ev_base = ev_cnt;
        send_byte(8'h1C);
        check("ovl_A", keyboard, 16'd65);
        send_byte(8'h32);
        check("ovl_B", keyboard, 16'd66);
        send_byte(8'hF0);
        send_byte(8'h1C);
        check("ovl_relA", keyboard, 16'd66);
        send_byte(8'hF0);
        send_byte(8'h32);
        check("ovl_relB", keyboard, 16'd0);
        check("events_ovl", ev_cnt - ev_base, 16'd3);

        // Typematic repeat and ignored AA.
        ev_base = ev_cnt;
        send_byte(8'h1C);
        send_byte(8'h1C);
        send_byte(8'h1C);
        check("typematic", keyboard, 16'd65);
        check("events_typ", ev_cnt - ev_base, 16'd1);
        send_byte(8'hAA);
        check("ignore_AA", keyboard, 16'd65);
        send_byte(8'hF0);
        send_byte(8'h1C);
        check("typ_rel", keyboard, 16'd0);

        // A few more mapping points.
        send_byte(8'h45);
        check("digit0", keyboard, 16'd48);
        send_byte(8'h07);
        check("f12", keyboard, 16'd152);
        send_byte(8'hE0);
        send_byte(8'h6C);
        check("home", keyboard, 16'd134);
        check("upper_zero", {8'd0, keyboard[15:8]}, 16'd0);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h6C);
        check("home_rel", keyboard, 16'd0);

        // Prefix timeout: stale F0 must not release the next 1C.
        send_byte(8'h1C);
        check("to_make", keyboard, 16'd65);
        send_byte(8'hF0);
        check("to_break", keyboard, 16'd65);
        repeat (20) @(negedge clk);
        send_byte(8'h1C);
        check("to_after", keyboard, 16'd65);
        send_byte(8'hF0);
        send_byte(8'h1C);
        check("to_rel", keyboard, 16'd0);

        // Async reset mid-prefix.
        send_byte(8'h1C);
        send_byte(8'hF0);
        check("rst_pre", keyboard, 16'd65);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("rst_async", keyboard, 16'd0);
        @(negedge clk);
        reset_n = 1'b1;
        send_byte(8'h1C);
        check("rst_make", keyboard, 16'd65);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
